// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FWFT FIFO: depth helper and the
// {pop,push} operation encoding used by the occupancy decode.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    localparam int DEF_ADDR_W = 4;
    localparam int DEPTH      = 1 << DEF_ADDR_W;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Push/pop handshake and status bundle of sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              push;
    logic [WIDTH-1:0]  push_data;
    logic              pop;
    logic [WIDTH-1:0]  pop_data;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, push, push_data, pop,
        input  pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, push, push_data, pop,
        output pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// WIDTH x 2**ADDR_W storage: synchronous write port, asynchronous read port
// so the head word falls through without a read cycle.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int MEM_DEPTH = fifo_depth(ADDR_W);

    logic [WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);
    localparam int CW         = ADDR_W + 1;
    localparam int FIFO_DEPTH = fifo_depth(ADDR_W);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
    localparam logic          AF_RST = (AF_THRESH == 0);

    logic [CW-1:0] w_ptr_reg, w_ptr_next;
    logic [CW-1:0] r_ptr_reg, r_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, almost_full_reg, almost_empty_reg;
    logic          overflow_reg, underflow_reg;
    logic          wr_acc, rd_acc;
    fifo_op_e      op;

    // A pop against a full FIFO frees the slot the simultaneous push lands in.
    always_comb begin
        wr_acc     = bus.push & (~full_reg | bus.pop);
        rd_acc     = bus.pop & ~empty_reg;
        op         = fifo_op_e'({rd_acc, wr_acc});
        w_ptr_next = w_ptr_reg;
        r_ptr_next = r_ptr_reg;
        count_next = count_reg;
        case (op)
            OP_PUSH: begin
                w_ptr_next = w_ptr_reg + 1'b1;
                count_next = count_reg + 1'b1;
            end
            OP_POP: begin
                r_ptr_next = r_ptr_reg + 1'b1;
                count_next = count_reg - 1'b1;
            end
            OP_BOTH: begin
                w_ptr_next = w_ptr_reg + 1'b1;
                r_ptr_next = r_ptr_reg + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_reg        <= '0;
            r_ptr_reg        <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= AF_RST;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else if (bus.clr) begin
            w_ptr_reg        <= '0;
            r_ptr_reg        <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= AF_RST;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            w_ptr_reg        <= w_ptr_next;
            r_ptr_reg        <= r_ptr_next;
            count_reg        <= count_next;
            // Wrap bits differ with equal low bits: the writer is a lap ahead.
            full_reg         <= (w_ptr_next[ADDR_W] != r_ptr_next[ADDR_W]) &&
                                (w_ptr_next[ADDR_W-1:0] == r_ptr_next[ADDR_W-1:0]);
            empty_reg        <= (w_ptr_next == r_ptr_next);
            almost_full_reg  <= (count_next >= AF_C);
            almost_empty_reg <= (count_next <= AE_C);
            if (bus.push && full_reg && !bus.pop) begin
                overflow_reg <= 1'b1;
            end
            if (bus.pop && empty_reg) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifo_mem_2p #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .wr_en (wr_acc & ~bus.clr),
        .waddr (w_ptr_reg[ADDR_W-1:0]),
        .wdata (bus.push_data),
        .raddr (r_ptr_reg[ADDR_W-1:0]),
        .rdata (bus.pop_data)
    );

    assign bus.full         = full_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_full  = almost_full_reg;
    assign bus.almost_empty = almost_empty_reg;
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

    initial begin : depth_guard
    end
endmodule
